// File: rtl/relu_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// relu_ctrl_pkg
// Shared definitions for the ReLU sequencer slice.
//   - state_t       : controller states (IDLE, RUN, DRAIN, DONE)
//   - rectify()     : ReLU / bounded-ReLU on a zero-extended N-bit value
//   - *_DEFAULT     : default parameter values for the top level
// Optional build macro: RELU_CLAMP_EN (consumed by relu_unit, which passes
// the resulting clamp setting into rectify()).
// ----------------------------------------------------------------------------
package relu_ctrl_pkg;

    localparam int N_DEFAULT         = 8;
    localparam int CNT_W_DEFAULT     = 8;
    localparam int CLAMP_MAX_DEFAULT = 6;

    // Fixed working width for rectify(); callers zero-extend their N-bit
    // value into it and keep only the low N bits of the result.
    localparam int RECT_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    // x carries an N-bit two's complement value in its low n bits with the
    // upper bits zero. Negative values rectify to zero; with clamping
    // enabled, non-negative values above clamp_max saturate to clamp_max.
    function automatic logic [RECT_W-1:0] rectify(
        input logic [RECT_W-1:0] x,
        input int                n,
        input logic              clamp_en,
        input logic [RECT_W-1:0] clamp_max
    );
        logic [RECT_W-1:0] r;
        r = x;
        if (x[n-1]) begin
            r = '0;
        end else if (clamp_en && (x > clamp_max)) begin
            r = clamp_max;
        end
        return r;
    endfunction

endpackage

// File: rtl/relu_add.sv
// ----------------------------------------------------------------------------
// ADD
// Generic ripple adder shared across the datapath library.
// Ports:
//   A, B : W-bit addends
//   CI   : carry in
//   S    : W-bit sum
//   CO   : carry out
// ----------------------------------------------------------------------------
module ADD #(
    parameter int W = 8
) (
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         CI,
    output logic [W-1:0] S,
    output logic         CO
);

    assign {CO, S} = {1'b0, A} + {1'b0, B} + {{W{1'b0}}, CI};

endmodule

// File: rtl/relu_unit.sv
// ----------------------------------------------------------------------------
// relu_unit
// Combinational share reconstruction plus rectification:
//   y = f((g + e) mod 2^N), f = ReLU, or bounded ReLU when RELU_CLAMP_EN
//   is defined (saturating at CLAMP_MAX).
// Ports:
//   g : N-bit garbler share
//   e : N-bit evaluator share
//   y : N-bit rectified result
// Optional build macro: RELU_CLAMP_EN
// N must be below 32 (the rectify working width).
// ----------------------------------------------------------------------------
module relu_unit
    import relu_ctrl_pkg::*;
#(
    parameter int N         = N_DEFAULT,
    parameter int CLAMP_MAX = CLAMP_MAX_DEFAULT
) (
    input  logic [N-1:0] g,
    input  logic [N-1:0] e,
    output logic [N-1:0] y
);

`ifdef RELU_CLAMP_EN
    localparam logic CLAMP_ON = 1'b1;
`else
    localparam logic CLAMP_ON = 1'b0;
`endif

    logic [N-1:0]        sum;
    logic                co_unused;
    logic [RECT_W-1:0]   rect_wide;
    logic [RECT_W-N-1:0] rect_hi_unused;

    // Modular share add: the carry out is deliberately dropped so the sum
    // wraps at 2^N.
    ADD #(.W(N)) u_add (
        .A  (g),
        .B  (e),
        .CI (1'b0),
        .S  (sum),
        .CO (co_unused)
    );

    always_comb begin
        rect_wide = rectify(RECT_W'(sum), N, CLAMP_ON, RECT_W'(CLAMP_MAX));
    end

    assign {rect_hi_unused, y} = rect_wide;

endmodule

// File: rtl/relu_seq_ctrl.sv
// ----------------------------------------------------------------------------
// relu_seq_ctrl
// Streams a vector of len secret-shared elements through relu_unit, one
// element per accepted beat, and signals completion.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start, len        : begin a vector of len elements (sampled in IDLE)
//   g_input, e_input  : shares of the current element
//   in_valid/in_ready : input handshake
//   o, out_valid      : registered rectified result
//   out_ready         : downstream accepts o
//   busy              : controller not idle
//   done              : one-cycle pulse after the last result is consumed
//   elem_idx          : index of the element currently held in o
// Optional build macro: RELU_CLAMP_EN (bounded ReLU in relu_unit)
// ----------------------------------------------------------------------------
module relu_seq_ctrl
    import relu_ctrl_pkg::*;
#(
    parameter int N         = N_DEFAULT,
    parameter int CNT_W     = CNT_W_DEFAULT,
    parameter int CLAMP_MAX = CLAMP_MAX_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic [N-1:0]     g_input,
    input  logic [N-1:0]     e_input,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [N-1:0]     o,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] elem_idx
);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] remaining;
    logic [CNT_W-1:0] accept_cnt;
    logic [N-1:0]     rect_value;
    logic             accept;
    logic             consume;

    relu_unit #(
        .N         (N),
        .CLAMP_MAX (CLAMP_MAX)
    ) u_relu (
        .g (g_input),
        .e (e_input),
        .y (rect_value)
    );

    // Next-state and handshake decode. in_ready allows a new element
    // whenever the output register is empty or is being drained this same
    // cycle, which gives bubble-free streaming under out_ready=1.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = (state != IDLE);
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                in_ready = (remaining != '0) && (!out_valid || out_ready);
                if (in_valid && in_ready && (remaining == CNT_W'(1))) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (out_valid && out_ready) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign accept  = in_valid && in_ready;
    assign consume = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Counters and output register. An accept always wins over a consume so
    // a coinciding pair replaces the held value without dropping out_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            remaining  <= '0;
            accept_cnt <= '0;
            o          <= '0;
            out_valid  <= 1'b0;
            elem_idx   <= '0;
        end else begin
            if ((state == IDLE) && start) begin
                remaining  <= len;
                accept_cnt <= '0;
            end
            if (accept) begin
                o          <= rect_value;
                out_valid  <= 1'b1;
                elem_idx   <= accept_cnt;
                accept_cnt <= accept_cnt + CNT_W'(1);
                remaining  <= remaining - CNT_W'(1);
            end else if (consume || (state == DONE)) begin
                out_valid  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_relu_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_relu_seq_ctrl
// Self-checking bench for relu_seq_ctrl: a transaction-level model checked
// every cycle, directed literal checks, then randomized traffic.
// Honours RELU_CLAMP_EN for expected values.
// ----------------------------------------------------------------------------
module tb_relu_seq_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] len;
    logic [7:0] g_input;
    logic [7:0] e_input;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] o;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       done;
    logic [7:0] elem_idx;

    int n_compared = 0;
    int n_mismatch = 0;

`ifdef RELU_CLAMP_EN
    localparam int EXP_08 = 6;
    localparam int EXP_7F = 6;
    localparam int EXP_11 = 6;
    localparam int EXP_22 = 6;
    localparam int EXP_07 = 6;
    localparam int EXP_09 = 6;
`else
    localparam int EXP_08 = 8;
    localparam int EXP_7F = 127;
    localparam int EXP_11 = 17;
    localparam int EXP_22 = 34;
    localparam int EXP_07 = 7;
    localparam int EXP_09 = 9;
`endif

    relu_seq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .g_input   (g_input),
        .e_input   (e_input),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .o         (o),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .elem_idx  (elem_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference rectifier from plain integer arithmetic.
    function automatic int ref_relu(input int g, input int e);
        int x;
        x = (g + e) % 256;
        if (x >= 128) return 0;
`ifdef RELU_CLAMP_EN
        if (x > 6) return 6;
`endif
        return x;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatch++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic [7:0] ln, input logic iv,
                                 input logic [7:0] g, input logic [7:0] e,
                                 input logic ordy, input logic r);
        start     = st;
        len       = ln;
        in_valid  = iv;
        g_input   = g;
        e_input   = e;
        out_ready = ordy;
        rst       = r;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level model: a vector is either active (with elements
    // left to accept and possibly one result held) or idle, and a done
    // pulse follows the consumption of the final result.
    bit m_active = 0;
    bit m_done   = 0;
    int m_rem    = 0;
    int m_cnt    = 0;
    bit m_hold_v = 0;
    int m_hold_val = 0;
    int m_hold_idx = 0;
    bit armed    = 0;

    always @(negedge clk) begin
        bit exp_rdy;
        bit acc;
        bit cons;
        exp_rdy = m_active && (m_rem > 0) && (!m_hold_v || out_ready);
        if (armed) begin
            checkOutput("in_ready",  in_ready,  exp_rdy);
            checkOutput("out_valid", out_valid, m_hold_v);
            checkOutput("o",         o,         m_hold_val);
            checkOutput("elem_idx",  elem_idx,  m_hold_idx);
            checkOutput("busy",      busy,      m_active || m_done);
            checkOutput("done",      done,      m_done);
        end
        acc  = in_valid && exp_rdy;
        cons = m_hold_v && out_ready;
        if (rst) begin
            m_active = 0; m_done = 0; m_rem = 0; m_cnt = 0;
            m_hold_v = 0; m_hold_val = 0; m_hold_idx = 0;
            armed = 1;
        end else if (m_done) begin
            m_done = 0;
        end else if (!m_active) begin
            if (start) begin
                if (len == 0) m_done = 1;
                else begin
                    m_active = 1; m_rem = len; m_cnt = 0;
                end
            end
        end else begin
            if ((m_rem == 0) && cons) begin
                m_active = 0; m_done = 1; m_hold_v = 0;
            end else if (acc) begin
                m_hold_val = ref_relu(g_input, e_input);
                m_hold_idx = m_cnt;
                m_cnt++;
                m_rem--;
                m_hold_v = 1;
            end else if (cons) begin
                m_hold_v = 0;
            end
        end
    end

    initial begin
        applyStimulus(0, 0, 0, 0, 0, 1, 1);
        step(); step();
        checkOutput("reset_o",    o,         0);
        checkOutput("reset_busy", busy,      0);
        checkOutput("reset_ov",   out_valid, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        step();

        // len=3 streaming at full throughput
        applyStimulus(1, 3, 0, 0, 0, 1, 0); step();
        checkOutput("t1_busy", busy, 1);
        applyStimulus(0, 0, 1, 8'h05, 8'h03, 1, 0); step();
        checkOutput("t1_o0", o, EXP_08);
        checkOutput("t1_i0", elem_idx, 0);
        applyStimulus(0, 0, 1, 8'hF0, 8'h05, 1, 0); step();
        checkOutput("t1_o1", o, 0);
        checkOutput("t1_i1", elem_idx, 1);
        applyStimulus(0, 0, 1, 8'h7F, 8'h00, 1, 0); step();
        checkOutput("t1_o2", o, EXP_7F);
        checkOutput("t1_i2", elem_idx, 2);
        applyStimulus(0, 0, 0, 0, 0, 1, 0); step();
        checkOutput("t1_done", done, 1);
        step();
        checkOutput("t1_done_off", done, 0);
        checkOutput("t1_idle", busy, 0);

        // wrap and sign boundaries
        applyStimulus(1, 3, 0, 0, 0, 1, 0); step();
        applyStimulus(0, 0, 1, 8'h80, 8'h00, 1, 0); step();
        checkOutput("w_80", o, 0);
        applyStimulus(0, 0, 1, 8'hFF, 8'h01, 1, 0); step();
        checkOutput("w_ff01", o, 0);
        checkOutput("w_ff01_v", out_valid, 1);
        applyStimulus(0, 0, 1, 8'h40, 8'h3F, 1, 0); step();
        checkOutput("w_7f", o, EXP_7F);
        applyStimulus(0, 0, 0, 0, 0, 1, 0); step(); step();

        // backpressure
        applyStimulus(1, 2, 0, 0, 0, 1, 0); step();
        applyStimulus(0, 0, 1, 8'h10, 8'h01, 1, 0); step();
        checkOutput("bp_o0", o, EXP_11);
        applyStimulus(0, 0, 1, 8'h20, 8'h02, 0, 0); #1;
        checkOutput("bp_rdy_lo", in_ready, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            checkOutput("bp_hold_o", o, EXP_11);
            checkOutput("bp_hold_v", out_valid, 1);
            checkOutput("bp_hold_rdy", in_ready, 0);
        end
        applyStimulus(0, 0, 1, 8'h20, 8'h02, 1, 0); #1;
        checkOutput("bp_rdy_hi", in_ready, 1);
        step();
        checkOutput("bp_o1", o, EXP_22);
        checkOutput("bp_v1", out_valid, 1);
        checkOutput("bp_i1", elem_idx, 1);
        applyStimulus(0, 0, 0, 0, 0, 1, 0); step();
        checkOutput("bp_done", done, 1);
        step();

        // len=0
        applyStimulus(1, 0, 0, 0, 0, 1, 0); step();
        checkOutput("z_done", done, 1);
        checkOutput("z_busy", busy, 1);
        checkOutput("z_ov", out_valid, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0); step();
        checkOutput("z_done_off", done, 0);

        // start during RUN is ignored
        applyStimulus(1, 2, 0, 0, 0, 1, 0); step();
        applyStimulus(1, 5, 1, 8'h01, 8'h01, 1, 0); step();
        applyStimulus(0, 0, 1, 8'h02, 8'h02, 1, 0); step();
        checkOutput("sr_o1", o, 4);
        applyStimulus(0, 0, 0, 0, 0, 1, 0); step();
        checkOutput("sr_done", done, 1);
        step();

        // reset mid-vector
        applyStimulus(1, 3, 0, 0, 0, 1, 0); step();
        applyStimulus(0, 0, 1, 8'h03, 8'h03, 1, 0); step();
        checkOutput("rs_v", out_valid, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1); step();
        checkOutput("rs_ov", out_valid, 0);
        checkOutput("rs_o", o, 0);
        checkOutput("rs_busy", busy, 0);
        checkOutput("rs_done", done, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0); step();
        checkOutput("rs_nodone", done, 0);
        applyStimulus(1, 1, 0, 0, 0, 1, 0); step();
        applyStimulus(0, 0, 1, 8'h07, 8'h00, 1, 0); step();
        checkOutput("rs_o_new", o, EXP_07);
        applyStimulus(0, 0, 0, 0, 0, 1, 0); step();
        checkOutput("rs_done_new", done, 1);
        step();

        // clamp-sensitive values
        applyStimulus(1, 3, 0, 0, 0, 1, 0); step();
        applyStimulus(0, 0, 1, 8'h04, 8'h05, 1, 0); step();
        checkOutput("c_09", o, EXP_09);
        applyStimulus(0, 0, 1, 8'h02, 8'h03, 1, 0); step();
        checkOutput("c_05", o, 5);
        applyStimulus(0, 0, 1, 8'hFE, 8'h00, 1, 0); step();
        checkOutput("c_fe", o, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0); step(); step();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 7) == 0,
                          8'($urandom_range(0, 5)),
                          $urandom_range(0, 2) != 0,
                          8'($urandom_range(0, 255)),
                          8'($urandom_range(0, 255)),
                          $urandom_range(0, 3) != 0,
                          $urandom_range(0, 199) == 0);
            step();
        end
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        repeat (10) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule

// File: doc/relu_seq_ctrl.md
Name: relu_seq_ctrl

Overview:
Sequencer that streams a vector of LEN secret-shared elements through one shared reconstruct-and-rectify datapath, one element per accepted beat. Each element is computed as x = g + e (mod 2^N), then ReLU is applied.
Owns the ready/valid handshakes, element counting and completion signalling, so a layer-level wrapper only issues start and len.
Sits between the share-input streams and the next layer's input buffer.

Parameters:
N, 8, bit-width of shares and result
CNT_W, 8, width of length/element counters (max LEN = 2^CNT_W-1)
CLAMP_MAX, 6, upper clamp value (used only with RELU_CLAMP_EN)

Ports:
clk  in  1  single clock, all state on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  pulse: begin a vector; sampled only in IDLE
len  in  CNT_W  element count, latched with start
g_input  in  N  garbler share of current element
e_input  in  N  evaluator share of current element
in_valid  in  1  shares valid
in_ready  out  1  controller accepts shares this cycle
o  out  N  rectified result
out_valid  out  1  o valid
out_ready  in  1  downstream accepts o
busy  out  1  state != IDLE
done  out  1  one-cycle pulse after last result consumed
elem_idx  out  CNT_W  index of element currently held in o

Behaviour:
- Reset values: state=IDLE, in_ready=0, out_valid=0, o=0, done=0, busy=0, elem_idx=0, internal counters=0.
- Reset asserted mid-vector aborts immediately. The in-flight result is discarded, there is no done pulse, and the block returns to IDLE the next cycle.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: on start, latch len into remaining and clear accept count. If len==0, go to DONE; otherwise go to RUN. start in any other state is ignored.
  - RUN: in_ready = (remaining != 0) && (!out_valid || out_ready).
    - An accept is in_valid && in_ready.
    - On accept: o <= f(g_input+e_input), out_valid <= 1, elem_idx <= accept count, accept count += 1, remaining -= 1.
    - Accepting the last element (remaining==1) moves to DRAIN.
  - DRAIN: in_ready=0. When out_valid && out_ready, go to DONE.
  - DONE: done=1 for exactly one cycle, out_valid=0, then IDLE. busy=1 during DONE.
- Output register: when out_valid && out_ready and there is no accept in the same cycle, out_valid <= 0. If consume and accept coincide, the new value replaces the old one, out_valid stays 1, and there is no bubble.
- Latency: result appears on o the cycle after accept. Full throughput is 1 element per cycle while out_ready=1.
- o is held stable while out_valid && !out_ready. in_valid may drop at any time; there is no penalty.
- Arithmetic:
  - x = (g_input + e_input) mod 2^N; carry-out discarded; x is interpreted as two's complement.
  - f(x) = 0 if x[N-1]=1, else x.
  - x = 2^(N-1) (most negative) gives 0.
- Counters: accept count wraps only past 2^CNT_W-1, which is unreachable because len ≤ 2^CNT_W-1.

Optional Feature:
RELU_CLAMP_EN
- Defined: f(x) = 0 if negative; CLAMP_MAX if x > CLAMP_MAX (unsigned compare on non-negative x); else x. This is the bounded-ReLU (ReLU6) variant.
- Undefined: plain ReLU as above, and CLAMP_MAX is unused.
- Handshake, latency and FSM are identical in both builds.

Decomposition:
- Package relu_ctrl_pkg holds:
  - state enum (IDLE/RUN/DRAIN/DONE)
  - rectify function taking x, N and the clamp setting
  - default parameter constants
- One combinational sub-module, relu_unit, performs share add plus rectify/clamp (N-bit in, N-bit out), reusing the existing ADD adder with CI=0 and CO unconnected.
- relu_seq_ctrl holds the FSM, counters and the output register.

Test Plan:
- Reset then start with len=3, N=8, out_ready=1, shares (0x05,0x03),(0xF0,0x05),(0x7F,0x00) → o = 0x08, 0x00, 0x7F on consecutive cycles; elem_idx 0,1,2; one done pulse 2 cycles after last accept.
- Wrap and boundary: shares (0x80,0x00) → 0x00; (0xFF,0x01) → 0x00 (sum wraps to 0); (0x40,0x3F) → 0x7F.
- Backpressure: len=2, out_ready=0 for 4 cycles after first accept → in_ready=0, o held at first value; release → second accepted same cycle as first consumed, with no bubble.
- len=0 start → DONE next cycle, done pulse, no out_valid ever; start asserted during RUN → ignored, remaining unchanged.
- rst asserted in RUN with out_valid=1 → next cycle out_valid=0, o=0, busy=0, no done; a fresh start with len=1 then completes normally.
- With RELU_CLAMP_EN defined, CLAMP_MAX=6: shares (0x04,0x05) → 0x06; (0x02,0x03) → 0x05; (0xFE,0x00) → 0x00.
